key_conditioner: RTL and testbench
==================================

# key_conditioner

Conditions the two raw, active-low push-buttons of the clock board into clean control events for the time-keeping/display block. Each key passes through a two-flop synchronizer, a per-key debounce state machine, and a hold timer. The block produces debounced levels, single-cycle press pulses, long-press pulses and optional auto-repeat. These replace the bare synchronizer/edge-detect in front of the set/mode logic, so a fast-stepped "mode" key can sweep hours, minutes or days without the user tapping repeatedly.

## Interface
- DEBOUNCE_CYCLES, 240000, consecutive stable synchronized samples needed to accept a press or release (10 ms at 24 MHz); ≥2
- HOLD_CYCLES, 12000000, cycles from debounced press to long-press event (500 ms); > DEBOUNCE_CYCLES
- REPEAT_CYCLES, 2400000, auto-repeat period after long-press (100 ms); ≥2
- REPEAT_EN, 2'b10, per-key auto-repeat enable (bit i for KEY[i])
- CLOCK_24  input  1  24 MHz board clock; all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- KEY  input  2  raw push-buttons, active-low, asynchronous to CLOCK_24
- key_down  output  2  debounced level, 1 = held
- key_press  output  2  1-cycle pulse on accepted press, and on each auto-repeat tick
- key_long  output  2  1-cycle pulse when a key has been held HOLD_CYCLES

## Operation
- Synchronizer: two flops per key capture !KEY, so "pressed" is a 1 at the second flop (sync[i]). Both flops reset to 0.
- Each key has its own FSM and counters. The keys never interact. Simultaneous activity on both keys is handled independently, and both keys may pulse in the same cycle.
- States and transitions:
  - IDLE: key_down=0. sync=1 → PRESS_WAIT with cnt=1.
  - PRESS_WAIT: sync=1 → cnt+1. When cnt reaches DEBOUNCE_CYCLES → DOWN, with key_press pulse and hold=0. sync=0 at any point → IDLE (bounce rejected, no output).
  - DOWN: key_down=1, and hold increments every cycle.
    - When hold reaches HOLD_CYCLES: key_long pulse. If REPEAT_EN[i] → REPEAT with rpt=0; else stay in DOWN with hold saturated.
    - sync=0 → RELEASE_WAIT with cnt=1.
  - REPEAT: key_down=1, and rpt increments. When rpt reaches REPEAT_CYCLES: key_press pulse, rpt=0. sync=0 → RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: key_down stays 1 and no pulses are produced.
    - sync=0 → cnt+1. When cnt reaches DEBOUNCE_CYCLES → IDLE with key_down=0.
    - sync=1 → back to the state it came from (DOWN or REPEAT), with hold/rpt unchanged (release bounce); no new key_press.
- Counter widths are sized to hold the largest parameter. No counter may wrap: hold saturates at HOLD_CYCLES, cnt resets on every state change.
- Only one pulse type can fire per key per cycle: key_long and the first repeat never coincide, because rpt starts at 0 on REPEAT entry.

## Timing
- All outputs are registered.
- Press latency: sync[i] goes to 1 two edges after the first edge that samples KEY[i]=0. With a stable press, key_down[i] and key_press[i] assert on the edge after DEBOUNCE_CYCLES consecutive sync=1 samples, i.e. DEBOUNCE_CYCLES+2 edges after first sampling.
- key_press and key_long are high for exactly one cycle.
- key_long fires HOLD_CYCLES cycles after key_down rose.
- The first repeat key_press comes REPEAT_CYCLES+1 cycles after key_long. Subsequent repeats come every REPEAT_CYCLES+1 cycles.
- Release latency: key_down falls DEBOUNCE_CYCLES+2 edges after first sampling KEY[i]=1, given a stable release.
- Reset, including mid-press or mid-repeat: asynchronously forces all FSMs to IDLE, all counters to 0, synchronizers to 0, and key_down=key_press=key_long=0.
  - A key still held after reset deasserts is treated as a fresh press: it is debounced and then pulses once.
- Repeated assertion of RESET while a key is held produces no pulse until RESET is low for DEBOUNCE_CYCLES+2 cycles.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, REPEAT_EN=2'b10.
- Clean press/release of KEY[0], held 30 cycles: key_down[0] rises 6 edges after first sampling KEY=0. One key_press[0] pulse, one key_long[0] pulse 20 cycles later, no repeats. key_down falls 6 edges after release.
- Bounce rejection: KEY[1] low for 3 cycles, high for 1, low for 3, then high: no key_press, key_down stays 0. A release glitch of 2 cycles while held gives no extra key_press and key_down stays 1.
- Auto-repeat on KEY[1], held 50 cycles after key_down: key_long[1] at +20, then key_press[1] at +26, +32, +38, +44, +50 (one cycle each). Release ends the repeats.
- Simultaneous: both keys pressed on the same edge: key_press[0] and key_press[1] pulse in the same cycle, and the levels and long events are independent.
- Reset mid-repeat: assert RESET asynchronously between clock edges during REPEAT: all outputs are 0 immediately. Deassert with KEY[1] held: a single fresh key_press[1] arrives 6 edges later.

Source files
------------

// File: rtl/key_conditioner.sv
// ============================================================================
// Module   : key_conditioner
// Purpose  : Two-key push-button conditioner. Each key is synchronized,
//            debounced and timed to produce a clean level, one-cycle press
//            pulses (with optional auto-repeat) and a one-cycle long-press
//            pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 240000,
    parameter int         HOLD_CYCLES     = 12000000,
    parameter int         REPEAT_CYCLES   = 2400000,
    parameter logic [1:0] REPEAT_EN       = 2'b10
) (
    input  logic       CLOCK_24,
    input  logic       RESET,
    input  logic [1:0] KEY,
    output logic [1:0] key_down,
    output logic [1:0] key_press,
    output logic [1:0] key_long
);

    // Each counter is just wide enough for the limit it compares against.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] c_DEB  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] c_HOLD = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] c_RPT  = RW'(REPEAT_CYCLES);

    // Two release-wait states remember where a release bounce must return to.
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_PRESS_WAIT = 3'd1;
    localparam logic [2:0] c_ST_DOWN       = 3'd2;
    localparam logic [2:0] c_ST_REPEAT     = 3'd3;
    localparam logic [2:0] c_ST_REL_DOWN   = 3'd4;
    localparam logic [2:0] c_ST_REL_RPT    = 3'd5;

    logic [1:0] meta_q;
    logic [1:0] sync_q;

    // Two-flop synchronizer; inverts the active-low keys so 1 means pressed.
    always_ff @(posedge CLOCK_24 or posedge RESET) begin
        if (RESET) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ~KEY;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic [2:0]    state_q, state_d;
        logic [DW-1:0] cnt_q, cnt_d;
        logic [HW-1:0] hold_q, hold_d;
        logic [RW-1:0] rpt_q, rpt_d;
        logic          down_q, down_d;
        logic          press_q, press_d;
        logic          long_q, long_d;

        logic          w_sync;
        logic [DW-1:0] w_cnt_inc;
        logic          w_cnt_done;
        logic [HW-1:0] w_hold_inc;
        logic          w_hold_hit;
        logic          w_rpt_hit;

        assign w_sync     = sync_q[i];
        assign w_cnt_inc  = cnt_q + DW'(1);
        assign w_cnt_done = (w_cnt_inc == c_DEB);
        assign w_hold_inc = hold_q + HW'(1);
        // Only a not-yet-saturated hold counter can produce the long event.
        assign w_hold_hit = (hold_q != c_HOLD) && (w_hold_inc == c_HOLD);
        assign w_rpt_hit  = (rpt_q == c_RPT);

        // State, counters and registered outputs.
        always_ff @(posedge CLOCK_24 or posedge RESET) begin
            if (RESET) begin
                state_q <= c_ST_IDLE;
                cnt_q   <= '0;
                hold_q  <= '0;
                rpt_q   <= '0;
                down_q  <= 1'b0;
                press_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                rpt_q   <= rpt_d;
                down_q  <= down_d;
                press_q <= press_d;
                long_q  <= long_d;
            end
        end

        // Next-state and counter update; a release sample takes priority
        // over hold/repeat advance so a releasing key never fires an event.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hold_d  = hold_q;
            rpt_d   = rpt_q;
            case (state_q)
                c_ST_IDLE: begin
                    if (w_sync) begin
                        state_d = c_ST_PRESS_WAIT;
                        cnt_d   = DW'(1);
                    end
                end
                c_ST_PRESS_WAIT: begin
                    if (!w_sync) begin
                        state_d = c_ST_IDLE;
                        cnt_d   = '0;
                    end else if (w_cnt_done) begin
                        state_d = c_ST_DOWN;
                        cnt_d   = '0;
                        hold_d  = '0;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                c_ST_DOWN: begin
                    if (!w_sync) begin
                        state_d = c_ST_REL_DOWN;
                        cnt_d   = DW'(1);
                    end else if (hold_q != c_HOLD) begin
                        hold_d = w_hold_inc;
                        if (w_hold_hit && REPEAT_EN[i]) begin
                            state_d = c_ST_REPEAT;
                            rpt_d   = '0;
                        end
                    end
                end
                c_ST_REPEAT: begin
                    if (!w_sync) begin
                        state_d = c_ST_REL_RPT;
                        cnt_d   = DW'(1);
                    end else if (w_rpt_hit) begin
                        rpt_d = '0;
                    end else begin
                        rpt_d = rpt_q + RW'(1);
                    end
                end
                c_ST_REL_DOWN, c_ST_REL_RPT: begin
                    if (w_sync) begin
                        state_d = (state_q == c_ST_REL_RPT) ? c_ST_REPEAT : c_ST_DOWN;
                        cnt_d   = '0;
                    end else if (w_cnt_done) begin
                        state_d = c_ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Output decode, registered alongside the state.
        always_comb begin
            down_d  = 1'b0;
            press_d = 1'b0;
            long_d  = 1'b0;
            case (state_q)
                c_ST_PRESS_WAIT: begin
                    down_d  = w_sync && w_cnt_done;
                    press_d = w_sync && w_cnt_done;
                end
                c_ST_DOWN: begin
                    down_d = 1'b1;
                    long_d = w_sync && w_hold_hit;
                end
                c_ST_REPEAT: begin
                    down_d  = 1'b1;
                    press_d = w_sync && w_rpt_hit;
                end
                c_ST_REL_DOWN, c_ST_REL_RPT: begin
                    down_d = w_sync || !w_cnt_done;
                end
                default: begin
                    down_d = 1'b0;
                end
            endcase
        end

        assign key_down[i]  = down_q;
        assign key_press[i] = press_q;
        assign key_long[i]  = long_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Directed and random stimulus for key_conditioner against an
//            event-level reference model (run lengths and held-time arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_conditioner;

    localparam int         DEB  = 4;
    localparam int         HOLD = 20;
    localparam int         RPT  = 5;
    localparam logic [1:0] REN  = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] down;
    logic [1:0] press;
    logic [1:0] lng;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (RPT),
        .REPEAT_EN      (REN)
    ) dut (
        .CLOCK_24 (clk),
        .RESET    (rst),
        .KEY      (key),
        .key_down (down),
        .key_press(press),
        .key_long (lng)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: synchronizer pipe, run length of the current sample
    // value, debounced level, and number of steady held cycles since press.
    logic [1:0] m_meta, m_sync, m_prev, m_down, e_press, e_long;
    int         m_run [2];
    int         m_act [2];

    task automatic model_clear();
        m_meta  = '0;
        m_sync  = '0;
        m_prev  = '0;
        m_down  = '0;
        e_press = '0;
        e_long  = '0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0;
            m_act[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [1:0] s;
        logic       steady;
        if (rst) begin
            model_clear();
            return;
        end
        s       = m_sync;
        e_press = '0;
        e_long  = '0;
        for (int i = 0; i < 2; i++) begin
            steady = m_down[i] && m_prev[i] && s[i];
            if (s[i] == m_prev[i]) m_run[i]++;
            else                   m_run[i] = 1;
            if (!m_down[i]) begin
                if (s[i] && m_run[i] == DEB) begin
                    m_down[i]  = 1'b1;
                    e_press[i] = 1'b1;
                    m_act[i]   = 0;
                end
            end else if (!s[i]) begin
                if (m_run[i] == DEB) m_down[i] = 1'b0;
            end else if (steady) begin
                m_act[i]++;
                if (m_act[i] == HOLD)
                    e_long[i] = 1'b1;
                else if (REN[i] && m_act[i] > HOLD && ((m_act[i] - HOLD) % (RPT + 1)) == 0)
                    e_press[i] = 1'b1;
            end
            m_prev[i] = s[i];
        end
        m_sync = m_meta;
        m_meta = ~key;
    endtask

    task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive keys at the falling edge, advance the model at the
    // rising edge, compare just after it.
    task automatic step(input logic [1:0] k);
        @(negedge clk);
        key = k;
        @(posedge clk);
        model_edge();
        #1;
        chk2("key_down", down, m_down);
        chk2("key_press", press, e_press);
        chk2("key_long", lng, e_long);
    endtask

    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        chk2("rst_down", down, 2'b00);
        chk2("rst_press", press, 2'b00);
        chk2("rst_long", lng, 2'b00);
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         rise, fall, np, nd, nl, lpos, len;
        int         rp [$];
        logic [1:0] first_press, k;

        model_clear();
        for (int t = 0; t < 3; t++) step(2'b11);
        chk2("reset_down", down, 2'b00);
        chk2("reset_press", press, 2'b00);
        chk2("reset_long", lng, 2'b00);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) step(2'b11);

        // Clean press of KEY[0], no auto-repeat on this key.
        rise = -1; np = 0; nl = 0; lpos = -1;
        for (int t = 1; t <= 40; t++) begin
            step(2'b10);
            if (rise < 0 && down[0]) rise = t;
            np += int'(press[0]);
            if (lng[0]) begin nl++; lpos = t; end
        end
        chki("k0_rise_edges", rise, DEB + 2);
        chki("k0_press_count", np, 1);
        chki("k0_long_count", nl, 1);
        chki("k0_long_delay", lpos - rise, HOLD);
        fall = -1;
        for (int t = 1; t <= 12; t++) begin
            step(2'b11);
            if (fall < 0 && !down[0]) fall = t;
        end
        chki("k0_fall_edges", fall, DEB + 2);

        // Press bounce on KEY[1] is rejected.
        np = 0; nd = 0;
        for (int t = 0; t < 15; t++) begin
            step((t < 3 || (t >= 4 && t < 7)) ? 2'b01 : 2'b11);
            np += int'(press[1]);
            nd += int'(down[1]);
        end
        chki("bounce_press", np, 0);
        chki("bounce_down", nd, 0);

        // Release glitch while held gives no extra press and keeps the level.
        for (int t = 0; t < 10; t++) step(2'b01);
        np = 0; nd = 0;
        for (int t = 0; t < 8; t++) begin
            step((t < 2) ? 2'b11 : 2'b01);
            np += int'(press[1]);
            nd += int'(!down[1]);
        end
        chki("glitch_press", np, 0);
        chki("glitch_down_drop", nd, 0);
        for (int t = 0; t < 12; t++) step(2'b11);

        // Auto-repeat on KEY[1].
        rise = -1;
        for (int t = 1; t <= 20; t++) begin
            step(2'b01);
            if (down[1]) begin rise = t; break; end
        end
        chki("k1_rise_edges", rise, DEB + 2);
        rp.delete(); lpos = -1;
        for (int t = 1; t <= 50; t++) begin
            step(2'b01);
            if (press[1]) rp.push_back(t);
            if (lng[1]) lpos = t;
        end
        chki("k1_long_at", lpos, HOLD);
        chki("k1_repeat_count", rp.size(), 5);
        for (int j = 0; j < rp.size(); j++)
            chki("k1_repeat_at", rp[j], HOLD + (j + 1) * (RPT + 1));
        np = 0;
        for (int t = 0; t < 12; t++) begin
            step(2'b11);
            np += int'(press[1]);
        end
        chki("k1_release_press", np, 0);

        // Both keys pressed on the same edge.
        first_press = 2'b00;
        for (int t = 0; t < 20; t++) begin
            step(2'b00);
            if (press != 2'b00) begin first_press = press; break; end
        end
        chk2("simul_first_press", first_press, 2'b11);
        for (int t = 0; t < 30; t++) step(2'b00);
        for (int t = 0; t < 12; t++) step(2'b11);

        // Reset mid-repeat, then a bounced reset with KEY[1] still held.
        for (int t = 0; t < 35; t++) step(2'b01);
        async_reset_check();
        for (int t = 0; t < 3; t++) step(2'b01);
        rst = 1'b0;
        for (int t = 0; t < 2; t++) step(2'b01);
        async_reset_check();
        for (int t = 0; t < 2; t++) step(2'b01);
        rst = 1'b0;
        rise = -1; np = 0;
        for (int t = 1; t <= 15; t++) begin
            step(2'b01);
            if (press[1]) begin
                np++;
                if (rise < 0) rise = t;
            end
        end
        chki("post_reset_press_at", rise, DEB + 2);
        chki("post_reset_press_count", np, 1);
        for (int t = 0; t < 12; t++) step(2'b11);

        // Random key activity with occasional short glitches and one reset.
        for (int seg = 0; seg < 60; seg++) begin
            k   = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            for (int j = 0; j < len; j++) step(k);
            if (seg == 30) begin
                async_reset_check();
                step(k);
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
